// File: rtl/axi_lite_regfile.sv
// AXI-Lite slave register bank: byte-strobed writes, read-only status slots
// sourced from RO_IN, and SLVERR for out-of-range or read-only writes.
module axi_lite_regfile #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           WVALID,
  output logic                           WREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  output logic                           BVALID,
  input  logic                           BREADY,
  output logic [1:0]                     BRESP,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic [NUM_REGS*DATA_WIDTH-1:0] REG_OUT,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] RO_IN
);

  localparam int STRB = DATA_WIDTH / 8;
  localparam int LSB  = $clog2(STRB);
  localparam int IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(NUM_REGS * STRB);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write-side holding registers and response
  logic                  aw_full_q, aw_full_d;
  logic [ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
  logic                  w_full_q,  w_full_d;
  logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
  logic [STRB-1:0]       wstrb_q,   wstrb_d;
  logic                  bvalid_q,  bvalid_d;
  logic [1:0]            bresp_q,   bresp_d;

  // Read-side response registers
  logic                  rvalid_q,  rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic [1:0]            rresp_q,   rresp_d;

  logic                  aw_hs, w_hs, ar_hs;
  logic                  wr_fire, wr_ok, ro_hit;
  logic                  aw_in_range, ar_in_range;
  logic [IDXW-1:0]       widx, ridx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [NUM_REGS*DATA_WIDTH-1:0] rd_src;
  logic                  unused_ro_in;

  // Readies drop during the reset cycle so nothing is accepted while clearing.
  assign AWREADY = !ARESET && !aw_full_q;
  assign WREADY  = !ARESET && !w_full_q;
  assign ARREADY = !ARESET && !rvalid_q;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID  && WREADY;
  assign ar_hs = ARVALID && ARREADY;

  assign aw_in_range = {1'b0, awaddr_q} < SPAN;
  assign ar_in_range = {1'b0, ARADDR}   < SPAN;
  assign widx = awaddr_q[LSB +: IDXW];
  assign ridx = ARADDR[LSB +: IDXW];

  assign wr_fire = aw_full_q && w_full_q && !bvalid_q;
  assign wr_ok   = wr_fire && aw_in_range && !ro_hit;

  // Slices of RO_IN behind writable slots are intentionally ignored.
  assign unused_ro_in = ^RO_IN;

  always_comb begin
    ro_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (widx == IDXW'(i) && RO_MASK[i]) ro_hit = 1'b1;
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ridx == IDXW'(i)) rd_word = rd_src[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (RO_MASK[gi]) begin : g_ro
        assign REG_OUT[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
        assign rd_src[gi*DATA_WIDTH +: DATA_WIDTH]  = RO_IN[gi*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_rw
        logic [DATA_WIDTH-1:0] val_q, val_d;

        always_comb begin
          val_d = val_q;
          if (wr_ok && widx == IDXW'(gi)) begin
            for (int k = 0; k < STRB; k++) begin
              if (wstrb_q[k]) val_d[k*8 +: 8] = wdata_q[k*8 +: 8];
            end
          end
        end

        always_ff @(posedge ACLK) begin
          if (ARESET) val_q <= RESET_VAL;
          else        val_q <= val_d;
        end

        assign REG_OUT[gi*DATA_WIDTH +: DATA_WIDTH] = val_q;
        assign rd_src[gi*DATA_WIDTH +: DATA_WIDTH]  = val_q;
      end
    end
  endgenerate

  always_comb begin
    aw_full_d = aw_full_q;
    awaddr_d  = awaddr_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      awaddr_d  = AWADDR;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d  = WDATA;
      wstrb_d  = WSTRB;
    end

    // A commit needs an idle B channel, so it never overlaps a handshake.
    if (wr_fire) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && BREADY) begin
      bvalid_d = 1'b0;
    end

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = ar_in_range ? rd_word : '0;
      rresp_d  = ar_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_full_q <= 1'b0;
      awaddr_q  <= '0;
      w_full_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      aw_full_q <= aw_full_d;
      awaddr_q  <= awaddr_d;
      w_full_q  <= w_full_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign BVALID = bvalid_q;
  assign BRESP  = bresp_q;
  assign RVALID = rvalid_q;
  assign RDATA  = rdata_q;
  assign RRESP  = rresp_q;

endmodule

// File: doc/axi_lite_regfile.md
Name: axi_lite_regfile

Overview:
Parametrised AXI-Lite slave register bank: NUM_REGS registers of DATA_WIDTH bits with byte-strobe writes, per-register read-only mapping and SLVERR decode. Terminates the AXI-Lite bus carried by the bench interface. Exposes register contents to fabric and samples status inputs for read-only slots. One write and one read may be outstanding at a time, independently.

Parameters:
ADDR_WIDTH, 32, byte-address width.
DATA_WIDTH, 32, data width; 32 or 64 only; STRB = DATA_WIDTH/8, LSB = log2(STRB).
NUM_REGS, 8, register count, 1..256.
RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only, sourced from RO_IN.
RESET_VAL, 0, DATA_WIDTH reset value for every writable register.

Ports:
ACLK  in  1  clock; all logic on posedge.
ARESET  in  1  synchronous reset, active-high.
AWVALID  in  1  write address valid.
AWREADY  out  1  write address ready.
AWADDR  in  ADDR_WIDTH  write byte address.
WVALID  in  1  write data valid.
WREADY  out  1  write data ready.
WDATA  in  DATA_WIDTH  write data.
WSTRB  in  DATA_WIDTH/8  byte enables.
BVALID  out  1  write response valid.
BREADY  in  1  write response ready.
BRESP  out  2  00 OKAY, 10 SLVERR.
ARVALID  in  1  read address valid.
ARREADY  out  1  read address ready.
ARADDR  in  ADDR_WIDTH  read byte address.
RVALID  out  1  read data valid.
RREADY  in  1  read data ready.
RDATA  out  DATA_WIDTH  read data.
RRESP  out  2  00 OKAY, 10 SLVERR.
REG_OUT  out  NUM_REGS*DATA_WIDTH  flat register contents; reg i at [i*DATA_WIDTH +: DATA_WIDTH].
RO_IN  in  NUM_REGS*DATA_WIDTH  status values for RO slots; other slices ignored.

Behaviour:
- Reset (ARESET=1 at posedge): AWREADY, WREADY, ARREADY, BVALID, RVALID = 0 during the reset cycle. BRESP, RRESP, RDATA = 0. Holding registers are emptied. Writable registers = RESET_VAL. Reset mid-transaction drops the transaction silently.
- After reset: AWREADY = !aw_full, WREADY = !w_full, ARREADY = !RVALID.
- Write channel:
  - AW and W are accepted independently, in either order or the same cycle, into one-entry holding registers (aw_full, w_full).
  - Commit edge: aw_full && w_full && !BVALID. On that edge the register is updated, holding registers clear, BVALID=1 and BRESP are set.
  - BVALID holds with stable BRESP until a BVALID&&BREADY edge.
  - New AW/W may be captured while BVALID=1, but do not commit until B completes.
- Decode:
  - idx = addr[LSB +: 8]; low LSB bits are ignored (unaligned addresses allowed).
  - Out of range if addr >= NUM_REGS*STRB: SLVERR, no update.
  - Write to an RO register: SLVERR, no update.
  - Otherwise byte k of register idx takes WDATA byte k where WSTRB[k]=1; WSTRB=0 gives OKAY, no change.
- Read channel:
  - On the ARVALID&&ARREADY edge, RDATA/RRESP are registered and RVALID=1 (data visible the cycle after accept).
  - Data source: RO register = RO_IN slice sampled at the accept edge; writable register = current contents; out of range = RDATA 0, SLVERR.
  - RVALID, RDATA, RRESP are held stable until RVALID&&RREADY. Maximum rate is one read per two cycles.
- Same-edge read accept and write commit to the same register: the read returns the pre-write value.
- REG_OUT is driven directly from register state: new value visible the cycle after the commit edge. RO slots of REG_OUT = 0.
- Read and write paths are fully independent; BREADY/RREADY backpressure of any length is legal.

Test Plan:
- Reset, then read reg 0 with NUM_REGS=8, RESET_VAL=32'hA5A5_0000 -> RDATA=A5A50000, RRESP=00; all VALID/READY outputs 0 during reset.
- AW 0x04 presented 3 cycles before W=DEADBEEF, WSTRB=1111 -> one BVALID, BRESP=00; REG_OUT[63:32]=DEADBEEF; repeat with W first, same result.
- Reg 1 = DEADBEEF, then write 0x04 data 11223344 WSTRB=0101 -> reg 1 = DE22BE44.
- Write 0x20 (out of range, 8 regs) -> BRESP=10, no REG_OUT change. Write to RO reg 2 (RO_MASK=8'h04) -> BRESP=10. Read 0x08 with RO_IN slice 2 = 0000CAFE -> RDATA=0000CAFE.
- Hold BREADY=0 for 5 cycles with a second AW/W already captured -> AWREADY/WREADY=0, second write commits only after the first B handshake. Hold RREADY=0 -> RDATA stable, ARREADY=0.
- Assert ARESET while BVALID=1 and aw_full=1 -> next cycle BVALID=0, holding registers empty, registers = RESET_VAL.
